montgomery_domain_converter: RTL and testbench

- Converts 256-bit operands into and out of the Montgomery domain for the Montgomery multiplier, with N = 2^255-19 and R = 2^256.
- Mode 0 (ENTER) computes x*R mod N using 256 modular doublings. Mode 1 (EXIT) computes x*R^-1 mod N using 256 modular halvings.
- Sits before and after the multiplier. Inputs are mapped into the domain once, multiplied repeatedly, and the final result is mapped back out.

---
 rtl/mont_pkg.sv | 21 ++
 rtl/mod_step.sv | 32 +++
 rtl/montgomery_domain_converter.sv | 86 ++++++++
 tb/tb_montgomery_domain_converter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared constants and types for the Montgomery domain converter
package mont_pkg;

    localparam int MONT_WIDTH = 256;
    localparam int MONT_ITERS = 256;

    // 2^255 - 19
    localparam logic [MONT_WIDTH-1:0] N_P25519 = {4'h7, {61{4'hf}}, 8'hed};

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDUCE,
        S_ITER
    } conv_state_t;

    typedef enum logic {
        MODE_ENTER = 1'b0,
        MODE_EXIT  = 1'b1
    } conv_mode_t;

endpackage

// File: rtl/mod_step.sv
// rtl/mod_step.sv - one modular doubling (ENTER) or halving (EXIT) step, input assumed < N
module mod_step
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  conv_mode_t       mode,
    output logic [WIDTH-1:0] next
);

    logic [WIDTH:0] n_ext;
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] dbl_sub;
    logic [WIDTH:0] half_sum;

    assign n_ext    = {1'b0, N_P25519[WIDTH-1:0]};
    assign dbl      = {x, 1'b0};
    assign dbl_sub  = dbl - n_ext;
    // Adding N to an odd value makes it even, so the halving is exact mod N.
    assign half_sum = x[0] ? ({1'b0, x} + n_ext) : {1'b0, x};

    always_comb begin
        next = x;
        if (mode == MODE_ENTER) begin
            next = (dbl >= n_ext) ? dbl_sub[WIDTH-1:0] : dbl[WIDTH-1:0];
        end else begin
            next = half_sum[WIDTH:1];
        end
    end

endmodule

// File: rtl/montgomery_domain_converter.sv
// rtl/montgomery_domain_converter.sv - maps operands into (x*R mod N) and out of (x*R^-1 mod N) the Montgomery domain
module montgomery_domain_converter
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH,
    parameter int ITERS = MONT_ITERS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finished,
    output logic             o_busy
);

    localparam int CW = $clog2(ITERS);

    conv_state_t      state;
    conv_mode_t       mode_r;
    logic [WIDTH-1:0] x_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   red_diff;
    logic [WIDTH-1:0] red_next;
    logic [WIDTH-1:0] step_next;

    // A borrow out of x - N means x was already below N.
    assign red_diff = {1'b0, x_r} - {1'b0, N_P25519[WIDTH-1:0]};
    assign red_next = red_diff[WIDTH] ? x_r : red_diff[WIDTH-1:0];

    mod_step #(.WIDTH(WIDTH)) u_step (
        .x    (x_r),
        .mode (mode_r),
        .next (step_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            mode_r     <= MODE_ENTER;
            x_r        <= '0;
            cnt        <= '0;
            o_result   <= '0;
            o_finished <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_finished <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        x_r    <= i_x;
                        mode_r <= conv_mode_t'(i_mode);
                        cnt    <= '0;
                        state  <= S_REDUCE;
                        o_busy <= 1'b1;
                    end
                end
                // Two conditional subtractions cover any 256-bit input (2^256-1 = 2N+37).
                S_REDUCE: begin
                    x_r <= red_next;
                    if (cnt == '0) begin
                        cnt <= CW'(1);
                    end else begin
                        cnt   <= '0;
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    x_r <= step_next;
                    if (cnt == CW'(ITERS - 1)) begin
                        o_result   <= step_next;
                        o_finished <= 1'b1;
                        o_busy     <= 1'b0;
                        cnt        <= '0;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_domain_converter.sv
// tb/tb_montgomery_domain_converter.sv - self-checking bench for montgomery_domain_converter
module tb_montgomery_domain_converter;
    import mont_pkg::*;

    localparam logic [255:0] N = N_P25519;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [255:0] x;
    logic [255:0] result;
    logic         finished;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] rinv;

    always #5 clk = ~clk;

    montgomery_domain_converter dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_mode     (mode),
        .i_x        (x),
        .o_result   (result),
        .o_finished (finished),
        .o_busy     (busy)
    );

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] p;
        p = {256'b0, a} * {256'b0, b};
        p = p % {256'b0, N};
        return p[255:0];
    endfunction

    function automatic logic [255:0] enter_ref(input logic [255:0] a);
        logic [511:0] p;
        p = {a, 256'b0} % {256'b0, N};
        return p[255:0];
    endfunction

    function automatic logic [255:0] exit_ref(input logic [255:0] a);
        return mulmod(a, rinv);
    endfunction

    function automatic logic [255:0] mont_ref(input logic [255:0] a, input logic [255:0] b);
        return mulmod(mulmod(a, b), rinv);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // R^-1 = 38^(N-2) mod N by Fermat, since R mod N = 38.
    function automatic logic [255:0] calc_rinv();
        logic [255:0] e, base, acc;
        e = N - 256'd2;
        base = 256'd38;
        acc = 256'd1;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) acc = mulmod(acc, base);
            base = mulmod(base, base);
        end
        return acc;
    endfunction

    task automatic run_op(input logic m, input logic [255:0] a, output logic [255:0] res,
                          output int edges, output bit busy_ok);
        mode  = m;
        x     = a;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        edges   = 0;
        busy_ok = 1'b1;
        while (!finished && edges < 400) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        n_tests++;
        if (finished !== 1'b1) begin
            n_fail++;
            $display("FAIL op_timeout: o_finished=%b after %0d edges, required 1", finished, edges);
        end
        res = result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        x     = '0;
        #12;
        n_tests++;
        if (result !== '0 || finished !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: result=%h finished=%b busy=%b, required 0/0/0", result, finished, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_enter_one();
        logic [255:0] r;
        int e;
        bit b;
        run_op(1'b0, 256'd1, r, e, b);
        n_tests++;
        if (r !== 256'd38) begin n_fail++; $display("FAIL enter_one: result=%0d required 38", r); end
        n_tests++;
        if (e != 258) begin n_fail++; $display("FAIL latency: edges=%0d required 258", e); end
        n_tests++;
        if (!b) begin n_fail++; $display("FAIL busy_high: busy dropped during op, required 1"); end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (finished !== 1'b0) begin n_fail++; $display("FAIL finished_width: finished=%b required 0", finished); end
    endtask

    task automatic test_known();
        logic [255:0] xs [5];
        logic [255:0] exps [5];
        logic         ms [5];
        logic [255:0] r;
        int e;
        bit b;
        xs[0] = 256'd38;       ms[0] = 1'b1; exps[0] = 256'd1;
        xs[1] = 256'd0;        ms[1] = 1'b0; exps[1] = 256'd0;
        xs[2] = N;             ms[2] = 1'b0; exps[2] = 256'd0;
        xs[3] = {256{1'b1}};   ms[3] = 1'b0; exps[3] = 256'd1406;
        xs[4] = N + 256'd38;   ms[4] = 1'b1; exps[4] = 256'd1;
        for (int i = 0; i < 5; i++) begin
            run_op(ms[i], xs[i], r, e, b);
            n_tests++;
            if (r !== exps[i]) begin
                n_fail++;
                $display("FAIL known_%0d: mode=%b x=%h result=%h required %h", i, ms[i], xs[i], r, exps[i]);
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [255:0] a, m, r;
        int e;
        bit b;
        for (int i = 0; i < 6; i++) begin
            a = rand256() % N;
            run_op(1'b0, a, m, e, b);
            n_tests++;
            if (m !== enter_ref(a)) begin n_fail++; $display("FAIL rt_enter: x=%h result=%h required %h", a, m, enter_ref(a)); end
            run_op(1'b1, m, r, e, b);
            n_tests++;
            if (r !== a) begin n_fail++; $display("FAIL rt_exit: result=%h required %h", r, a); end
        end
        for (int i = 0; i < 4; i++) begin
            a = rand256();
            run_op(1'b1, a, r, e, b);
            n_tests++;
            if (r !== exit_ref(a)) begin n_fail++; $display("FAIL exit_full: x=%h result=%h required %h", a, r, exit_ref(a)); end
        end
    endtask

    task automatic test_chain();
        logic [255:0] a, bb, am, bm, pm, r;
        int e;
        bit b;
        for (int i = 0; i < 31; i++) begin
            if (i == 0) begin a = 256'd3; bb = 256'd5; end
            else begin a = rand256() % N; bb = rand256() % N; end
            run_op(1'b0, a, am, e, b);
            run_op(1'b0, bb, bm, e, b);
            n_tests++;
            if (am !== enter_ref(a) || bm !== enter_ref(bb)) begin
                n_fail++;
                $display("FAIL chain_enter_%0d: am=%h bm=%h required %h %h", i, am, bm, enter_ref(a), enter_ref(bb));
            end
            pm = mont_ref(am, bm);
            run_op(1'b1, pm, r, e, b);
            n_tests++;
            if (r !== mulmod(a, bb)) begin
                n_fail++;
                $display("FAIL chain_%0d: result=%h required %h", i, r, mulmod(a, bb));
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [255:0] a;
        int pulses, first;
        a = rand256();
        mode  = 1'b0;
        x     = a;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        first  = -1;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (cyc == 10 || cyc == 100) begin start = 1'b1; x = rand256(); mode = 1'b1; end
            else start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (finished === 1'b1) begin
                pulses++;
                if (first < 0) first = cyc;
            end
        end
        start = 1'b0;
        n_tests++;
        if (pulses != 1) begin n_fail++; $display("FAIL ignored_pulses: pulses=%0d required 1", pulses); end
        n_tests++;
        if (first != 258) begin n_fail++; $display("FAIL ignored_latency: edges=%0d required 258", first); end
        n_tests++;
        if (result !== enter_ref(a)) begin n_fail++; $display("FAIL ignored_result: result=%h required %h", result, enter_ref(a)); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] a1, a2, r1, r2;
        int e1, e2;
        bit b;
        @(negedge clk);
        a1 = rand256();
        a2 = rand256() % N;
        run_op(1'b0, a1, r1, e1, b);
        run_op(1'b1, a2, r2, e2, b);
        n_tests++;
        if (e2 != 258) begin n_fail++; $display("FAIL b2b_latency: edges=%0d required 258", e2); end
        n_tests++;
        if (r1 !== enter_ref(a1) || r2 !== exit_ref(a2)) begin
            n_fail++;
            $display("FAIL b2b_results: r1=%h r2=%h required %h %h", r1, r2, enter_ref(a1), exit_ref(a2));
        end
    endtask

    task automatic test_hold();
        logic [255:0] a, r, prev;
        int e;
        bit b;
        a = rand256();
        run_op(1'b0, a, prev, e, b);
        repeat (20) @(negedge clk);
        n_tests++;
        if (result !== enter_ref(a)) begin n_fail++; $display("FAIL hold_idle: result=%h required %h", result, enter_ref(a)); end
        mode  = 1'b1;
        x     = rand256();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        n_tests++;
        if (result !== enter_ref(a)) begin n_fail++; $display("FAIL hold_busy: result=%h required %h", result, enter_ref(a)); end
        repeat (200) @(negedge clk);
        n_tests++;
        if (result !== exit_ref(x)) begin n_fail++; $display("FAIL hold_next: result=%h required %h", result, exit_ref(x)); end
    endtask

    task automatic test_reset_mid();
        logic [255:0] a, r;
        int pulses, e;
        bit b;
        mode  = 1'b0;
        x     = rand256();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (122) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (result !== '0 || busy !== 1'b0 || finished !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: result=%h busy=%b finished=%b required 0/0/0", result, busy, finished);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (finished === 1'b1 || busy === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin n_fail++; $display("FAIL reset_abort: activity=%0d cycles required 0", pulses); end
        a = rand256();
        run_op(1'b1, a, r, e, b);
        n_tests++;
        if (r !== exit_ref(a) || e != 258) begin
            n_fail++;
            $display("FAIL reset_fresh: result=%h edges=%0d required %h 258", r, e, exit_ref(a));
        end
    endtask

    initial begin
        rinv = calc_rinv();
        test_reset();
        test_enter_one();
        test_known();
        test_roundtrip();
        test_chain();
        test_ignored_start();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
